// File: rtl/ifetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues single outstanding word reads
// to instruction memory, buffers returned words with their PCs in a small FIFO and
// hands them to the core over valid/ready. Redirect flushes, halt stops fetching.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_idle
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [15:0]     fetch_pc_q, fetch_pc_d;
    logic [15:0]     out_pc_q, out_pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            outstanding_q, outstanding_d;
    logic            discard_q, discard_d;
    logic            halted_q, halted_d;
    logic [15:0]     word_q [DEPTH];
    logic [15:0]     pc_q   [DEPTH];

    logic accept, resp, push, pop;

    // A request is only raised when a FIFO slot is guaranteed for its response.
    assign imem_req   = rst_n && !halted_q && !halt && !redirect && !outstanding_q &&
                        (count_q < CntFull);
    assign imem_addr  = fetch_pc_q;
    assign accept     = imem_req && imem_gnt;
    assign resp       = imem_rvalid && outstanding_q;
    assign inst_valid = (count_q != '0) && !redirect;
    assign pop        = inst_valid && inst_ready;
    assign push       = resp && !discard_q && !redirect;
    assign inst       = word_q[rd_ptr_q];
    assign inst_pc    = pc_q[rd_ptr_q];
    assign fetch_idle = halted_q && !outstanding_q && (count_q == '0);

    // Next-state logic; redirect overrides accept, push and pop.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        out_pc_d      = out_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        halted_d      = halted_q | halt;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            if (resp) begin
                // Response in the redirect cycle is dropped on the spot.
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end else if (outstanding_q) begin
                discard_d = 1'b1;
            end
        end else begin
            if (accept) begin
                outstanding_d = 1'b1;
                out_pc_d      = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 16'd1;
            end
            if (resp) begin
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_d = count_q + CntW'(1);
            else if (pop && !push) count_d = count_q - CntW'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            out_pc_q      <= 16'h0000;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            out_pc_q      <= out_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            halted_q      <= halted_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '{default: '0};
            pc_q   <= '{default: '0};
        end else if (push) begin
            word_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]   <= out_pc_q;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a single-outstanding memory model
// returning mem[a] = 16'hA000 + a after a programmable latency.
module tb_ifetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic        fetch_idle;

    int checks = 0;
    int errors = 0;

    // memory model state
    bit          acc;
    logic [15:0] acc_addr;
    bit          pend = 0;
    logic [15:0] paddr;
    int          pcnt;
    int          mem_lat = 1;
    int          req_cnt;

    ifetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .fetch_idle  (fetch_idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: capture the handshake before the edge, then advance the memory model.
    task automatic tick();
        #1;
        acc      = imem_req && imem_gnt;
        acc_addr = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (acc) begin
            pend  = 1;
            paddr = acc_addr;
            pcnt  = mem_lat;
        end
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 16'hA000 + paddr;
                pend        = 0;
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        inst_ready  = 1'b1;
        tick();
        tick();

        // reset values
        chk("rst_req", imem_req, 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", inst_valid, 16'd0);
        chk("rst_inst", inst, 16'h0000);
        chk("rst_pc", inst_pc, 16'h0000);
        chk("rst_idle", fetch_idle, 16'd0);

        // streaming: one word every 2 cycles
        rst_n = 1'b1;
        #1;
        chk("first_req", imem_req, 16'd1);
        chk("first_addr", imem_addr, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_odd_req", imem_req, 16'd0);
            chk("stream_odd_valid", inst_valid, 16'd0);
            tick();
            chk("stream_valid", inst_valid, 16'd1);
            chk("stream_pc", inst_pc, 16'(i));
            chk("stream_inst", inst, 16'hA000 + 16'(i));
            chk("stream_req", imem_req, 16'd1);
            chk("stream_addr", imem_addr, 16'(i + 1));
        end

        // backpressure: FIFO fills with PCs 3..6, requests stop
        inst_ready = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_req) req_cnt++;
        end
        chk("full_req_pulses", 16'(req_cnt), 16'd2);
        chk("full_req", imem_req, 16'd0);
        chk("full_addr", imem_addr, 16'd7);

        // drain back-to-back, fetch resumes at PC 7
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", inst_valid, 16'd1);
            chk("drain_pc", inst_pc, 16'(3 + i));
            chk("drain_inst", inst, 16'hA003 + 16'(i));
            if (i == 1) begin
                chk("resume_req", imem_req, 16'd1);
                chk("resume_addr", imem_addr, 16'd7);
            end
            tick();
        end
        chk("post_drain_pc", inst_pc, 16'd8);

        // redirect while read of PC 9 is outstanding, 3-cycle memory
        inst_ready = 1'b0;
        mem_lat    = 3;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        inst_ready  = 1'b1;
        #1;
        chk("redir_valid", inst_valid, 16'd0);
        chk("redir_req", imem_req, 16'd0);
        tick();
        redirect = 1'b0;
        mem_lat  = 1;
        #1;
        chk("redir_flushed", inst_valid, 16'd0);
        chk("redir_wait_req", imem_req, 16'd0);
        chk("redir_addr", imem_addr, 16'h0040);
        tick();
        chk("redir_dropped", inst_valid, 16'd0);
        chk("redir_new_req", imem_req, 16'd1);
        chk("redir_new_addr", imem_addr, 16'h0040);
        tick();
        tick();
        chk("redir_head_valid", inst_valid, 16'd1);
        chk("redir_head_pc", inst_pc, 16'h0040);
        chk("redir_head_inst", inst, 16'hA040);

        // redirect coincident with rvalid and inst_ready
        inst_ready = 1'b0;
        tick();
        chk("coin_rvalid", imem_rvalid, 16'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        inst_ready  = 1'b1;
        #1;
        chk("coin_valid", inst_valid, 16'd0);
        chk("coin_req", imem_req, 16'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("coin_empty", inst_valid, 16'd0);
        chk("coin_req_after", imem_req, 16'd1);
        chk("coin_addr", imem_addr, 16'h1234);
        tick();
        tick();
        chk("coin_head_pc", inst_pc, 16'h1234);
        chk("coin_head_inst", inst, 16'hB234);

        // PC wrap at 16'hFFFF
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        #1;
        chk("wrap_req", imem_req, 16'd1);
        chk("wrap_addr", imem_addr, 16'hFFFE);
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
            chk("wrap_valid", inst_valid, 16'd1);
            chk("wrap_pc", inst_pc, 16'hFFFE + 16'(i));
            chk("wrap_inst", inst, 16'h9FFE + 16'(i));
        end

        // halt with one read outstanding and two words queued
        inst_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("halt_head_pc", inst_pc, 16'd1);
        halt = 1'b1;
        #1;
        chk("halt_req", imem_req, 16'd0);
        tick();
        halt       = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("halt_sticky_req", imem_req, 16'd0);
        chk("halt_idle0", fetch_idle, 16'd0);
        for (int i = 0; i < 3; i++) begin
            chk("halt_drain_valid", inst_valid, 16'd1);
            chk("halt_drain_pc", inst_pc, 16'(1 + i));
            chk("halt_drain_inst", inst, 16'hA001 + 16'(i));
            chk("halt_drain_idle", fetch_idle, 16'd0);
            chk("halt_drain_req", imem_req, 16'd0);
            tick();
        end
        chk("halt_empty", inst_valid, 16'd0);
        chk("halt_idle", fetch_idle, 16'd1);
        chk("halt_req_end", imem_req, 16'd0);

        // redirect while halted loads PC but does not fetch
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        chk("hredir_req", imem_req, 16'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("hredir_addr", imem_addr, 16'h0100);
        chk("hredir_req_after", imem_req, 16'd0);
        chk("hredir_idle", fetch_idle, 16'd1);

        // asynchronous reset mid-operation; stray response afterwards is ignored
        rst_n = 1'b0;
        #1;
        chk("mrst_addr", imem_addr, 16'h0000);
        chk("mrst_idle", fetch_idle, 16'd0);
        chk("mrst_req", imem_req, 16'd0);
        tick();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        #1;
        chk("mrst_req_after", imem_req, 16'd1);
        chk("mrst_addr_after", imem_addr, 16'h0000);
        tick();
        chk("stray_ignored", inst_valid, 16'd0);
        tick();
        chk("mrst_head_valid", inst_valid, 16'd1);
        chk("mrst_head_pc", inst_pc, 16'h0000);
        chk("mrst_head_inst", inst, 16'hA000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
